// File: rtl/gpio_pkg.sv
// Shared GPIO register offsets, width limit and address decode helper.
// Included by the controller, the bench and mirrored in software headers.
package gpio_pkg;

    localparam int GPIO_MAX_WIDTH = 32;

    localparam logic [31:0] GPIO_DATA_IN    = 32'h00;
    localparam logic [31:0] GPIO_DATA_OUT   = 32'h04;
    localparam logic [31:0] GPIO_DIR        = 32'h08;
    localparam logic [31:0] GPIO_OUT_SET    = 32'h0C;
    localparam logic [31:0] GPIO_OUT_CLR    = 32'h10;
    localparam logic [31:0] GPIO_OUT_TGL    = 32'h14;
    localparam logic [31:0] GPIO_RISE_EN    = 32'h18;
    localparam logic [31:0] GPIO_FALL_EN    = 32'h1C;
    localparam logic [31:0] GPIO_IRQ_STATUS = 32'h20;

    typedef enum logic [3:0] {
        REG_DATA_IN,
        REG_DATA_OUT,
        REG_DIR,
        REG_OUT_SET,
        REG_OUT_CLR,
        REG_OUT_TGL,
        REG_RISE_EN,
        REG_FALL_EN,
        REG_IRQ_STATUS,
        REG_NONE
    } gpio_reg_e;

    // Offsets must match exactly; unaligned byte addresses fall into REG_NONE.
    function automatic gpio_reg_e gpio_decode(input logic [31:0] off);
        gpio_reg_e r;
        r = REG_NONE;
        case (off)
            GPIO_DATA_IN:    r = REG_DATA_IN;
            GPIO_DATA_OUT:   r = REG_DATA_OUT;
            GPIO_DIR:        r = REG_DIR;
            GPIO_OUT_SET:    r = REG_OUT_SET;
            GPIO_OUT_CLR:    r = REG_OUT_CLR;
            GPIO_OUT_TGL:    r = REG_OUT_TGL;
            GPIO_RISE_EN:    r = REG_RISE_EN;
            GPIO_FALL_EN:    r = REG_FALL_EN;
            GPIO_IRQ_STATUS: r = REG_IRQ_STATUS;
            default:         r = REG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gpio_ctrl_if.sv
// Simple peripheral bus: single-cycle writes on bSel & bWrite, combinational reads.
// No wait states and no backpressure; the master owns select/address/data.
interface gpio_ctrl_if;

    logic        bSel;
    logic        bWrite;
    logic [31:0] bAddr;
    logic [31:0] bWData;
    logic [31:0] bRData;

    modport master (output bSel, output bWrite, output bAddr, output bWData, input bRData);
    modport slave  (input bSel, input bWrite, input bAddr, input bWData, output bRData);

endinterface

// File: rtl/gpio_sync.sv
// WIDTH-bit two-flop synchroniser for asynchronous inputs; 2 clk edges of latency.
// Free-running, no flow control; async active-high reset clears both stages.
module gpio_sync #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] s1_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign s1_o = s1_q;
    assign q_o  = s2_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Bus-mapped GPIO: direction, atomic set/clr/tgl, synchronised inputs, edge IRQs.
// Writes take effect on the write edge; reads are combinational with no wait states.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    gpio_ctrl_if.slave       bus,
    input  logic [WIDTH-1:0] gpioInput,
    output logic [WIDTH-1:0] gpioOutput,
    output logic [WIDTH-1:0] gpioOe,
    output logic             irq
);

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] irq_status_q, irq_status_d;
    logic [WIDTH-1:0] s1_unused, s2, s3_q;

    logic [31:0]      offset;
    gpio_reg_e        reg_sel;
    logic             wr_en;
    logic [WIDTH-1:0] wdat;
    logic [WIDTH-1:0] rise, fall, evt, w1c;
    logic [31:0]      rdata;
    logic             unused_bus_bits;

    gpio_sync #(.WIDTH(WIDTH)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d_i  (gpioInput),
        .s1_o (s1_unused),
        .q_o  (s2)
    );

    assign offset  = 32'(bus.bAddr[ADDR_W-1:0]);
    assign reg_sel = gpio_decode(offset);
    assign wr_en   = bus.bSel & bus.bWrite;
    assign wdat    = bus.bWData[WIDTH-1:0];

    // s3 is a third stage kept only for edge detection; DATA_IN stays at s2.
    assign rise = s2 & ~s3_q;
    assign fall = ~s2 & s3_q;
    assign evt  = (rise & rise_en_q) | (fall & fall_en_q);
    assign w1c  = (wr_en && reg_sel == REG_IRQ_STATUS) ? wdat : '0;

    always_comb begin
        data_out_d   = data_out_q;
        dir_d        = dir_q;
        rise_en_d    = rise_en_q;
        fall_en_d    = fall_en_q;
        if (wr_en) begin
            case (reg_sel)
                REG_DATA_OUT: data_out_d = wdat;
                REG_DIR:      dir_d      = wdat;
                REG_OUT_SET:  data_out_d = data_out_q | wdat;
                REG_OUT_CLR:  data_out_d = data_out_q & ~wdat;
                REG_OUT_TGL:  data_out_d = data_out_q ^ wdat;
                REG_RISE_EN:  rise_en_d  = wdat;
                REG_FALL_EN:  fall_en_d  = wdat;
                default:      ;
            endcase
        end
        // A new event outranks a same-cycle clear so no edge is ever lost.
        irq_status_d = (irq_status_q & ~w1c) | evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q   <= '0;
            dir_q        <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            irq_status_q <= '0;
            s3_q         <= '0;
        end else begin
            data_out_q   <= data_out_d;
            dir_q        <= dir_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            irq_status_q <= irq_status_d;
            s3_q         <= s2;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_DATA_IN:    rdata = 32'(s2);
            REG_DATA_OUT:   rdata = 32'(data_out_q);
            REG_DIR:        rdata = 32'(dir_q);
            REG_RISE_EN:    rdata = 32'(rise_en_q);
            REG_FALL_EN:    rdata = 32'(fall_en_q);
            REG_IRQ_STATUS: rdata = 32'(irq_status_q);
            default:        rdata = '0;
        endcase
    end

    assign bus.bRData = rdata;
    assign gpioOutput = data_out_q;
    assign gpioOe     = dir_q;
    assign irq        = |irq_status_q;

    assign unused_bus_bits = ^{bus.bAddr, bus.bWData, s1_unused};

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: a WIDTH=16 instance for the main behaviour and
// a WIDTH=8 instance for width masking and out-of-map accesses.
module tb_gpio_ctrl;
    import gpio_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pins16 = '0;
    logic [15:0] out16, oe16;
    logic        irq16;
    logic [7:0]  pins8 = '0;
    logic [7:0]  out8, oe8;
    logic        irq8;

    int errs   = 0;
    int checks = 0;

    gpio_ctrl_if bus16 ();
    gpio_ctrl_if bus8 ();

    gpio_ctrl #(.WIDTH(16), .ADDR_W(6)) dut16 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus16),
        .gpioInput  (pins16),
        .gpioOutput (out16),
        .gpioOe     (oe16),
        .irq        (irq16)
    );

    gpio_ctrl #(.WIDTH(8), .ADDR_W(6)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus8),
        .gpioInput  (pins8),
        .gpioOutput (out8),
        .gpioOe     (oe8),
        .irq        (irq8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus16.bSel = 1'b0; bus16.bWrite = 1'b0; bus16.bWData = '0;
        bus8.bSel  = 1'b0; bus8.bWrite  = 1'b0; bus8.bWData  = '0;
    endtask

    task automatic wr(input bit w8, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        if (w8) begin
            bus8.bSel = 1'b1; bus8.bWrite = 1'b1; bus8.bAddr = a; bus8.bWData = d;
        end else begin
            bus16.bSel = 1'b1; bus16.bWrite = 1'b1; bus16.bAddr = a; bus16.bWData = d;
        end
        @(negedge clk);
        bus_idle();
    endtask

    task automatic rd(input bit w8, input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        if (w8) bus8.bAddr = a; else bus16.bAddr = a;
        #1;
        v = w8 ? bus8.bRData : bus16.bRData;
        chk(tag, v, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus_idle();
        bus16.bAddr = '0;
        bus8.bAddr  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(out16), 32'h0);
        chk("rst_oe", 32'(oe16), 32'h0);
        chk("rst_irq", 32'(irq16), 32'h0);
        rst = 1'b0;
        cycles(1);
        rd(0, "rst_status", GPIO_IRQ_STATUS, 32'h0);

        // Set / clear / toggle
        wr(0, GPIO_DATA_OUT, 32'h00F0);
        rd(0, "out_wr", GPIO_DATA_OUT, 32'h00F0);
        chk("pin_wr", 32'(out16), 32'h00F0);
        wr(0, GPIO_OUT_SET, 32'h0003);
        rd(0, "out_set", GPIO_DATA_OUT, 32'h00F3);
        chk("pin_set", 32'(out16), 32'h00F3);
        wr(0, GPIO_OUT_CLR, 32'h0010);
        rd(0, "out_clr", GPIO_DATA_OUT, 32'h00E3);
        chk("pin_clr", 32'(out16), 32'h00E3);
        wr(0, GPIO_OUT_TGL, 32'h8001);
        rd(0, "out_tgl", GPIO_DATA_OUT, 32'h80E2);
        chk("pin_tgl", 32'(out16), 32'h80E2);
        rd(0, "wo_reads0", GPIO_OUT_SET, 32'h0);
        wr(0, GPIO_DIR, 32'hFFFF_A5A5);
        rd(0, "dir_rd", GPIO_DIR, 32'hA5A5);
        chk("oe_pins", 32'(oe16), 32'hA5A5);
        wr(0, GPIO_DIR, 32'h0);

        // Synchroniser latency, DIR=0 then DIR=all-out
        @(negedge clk);
        pins16 = 16'h1234;
        @(posedge clk); #1;
        rd(0, "sync_e1", GPIO_DATA_IN, 32'h0);
        @(posedge clk); #1;
        rd(0, "sync_e2", GPIO_DATA_IN, 32'h1234);
        wr(0, GPIO_DATA_IN, 32'hFFFF);
        rd(0, "ro_ignored", GPIO_DATA_IN, 32'h1234);
        @(negedge clk);
        pins16 = 16'h0000;
        cycles(3);
        wr(0, GPIO_DIR, 32'hFFFF);
        @(negedge clk);
        pins16 = 16'h1234;
        @(posedge clk); #1;
        rd(0, "sync_dir_e1", GPIO_DATA_IN, 32'h0);
        @(posedge clk); #1;
        rd(0, "sync_dir_e2", GPIO_DATA_IN, 32'h1234);

        // Edge interrupts
        @(negedge clk);
        pins16 = 16'h0002;
        cycles(4);
        wr(0, GPIO_RISE_EN, 32'h0001);
        wr(0, GPIO_FALL_EN, 32'h0002);
        rd(0, "irq_quiet", GPIO_IRQ_STATUS, 32'h0);
        pins16 = 16'h0003;
        @(posedge clk); @(posedge clk); #1;
        rd(0, "rise_e2", GPIO_IRQ_STATUS, 32'h0);
        @(posedge clk); #1;
        rd(0, "rise_e3", GPIO_IRQ_STATUS, 32'h0001);
        chk("irq_rise", 32'(irq16), 32'h1);
        @(negedge clk);
        pins16 = 16'h0002;
        cycles(4);
        pins16 = 16'h0000;
        cycles(3);
        rd(0, "fall_pin1", GPIO_IRQ_STATUS, 32'h0003);
        pins16 = 16'h0004;
        cycles(4);
        pins16 = 16'h0000;
        cycles(4);
        rd(0, "no_en_pin2", GPIO_IRQ_STATUS, 32'h0003);
        wr(0, GPIO_RISE_EN, 32'h0);
        rd(0, "en_clr_keeps", GPIO_IRQ_STATUS, 32'h0003);
        wr(0, GPIO_IRQ_STATUS, 32'h0002);
        rd(0, "w1c_bit1", GPIO_IRQ_STATUS, 32'h0001);
        wr(0, GPIO_IRQ_STATUS, 32'h0001);
        rd(0, "w1c_all", GPIO_IRQ_STATUS, 32'h0);
        chk("irq_low", 32'(irq16), 32'h0);

        // W1C colliding with a new event on the same bit
        wr(0, GPIO_RISE_EN, 32'h0001);
        pins16 = 16'h0001;
        cycles(3);
        rd(0, "pend", GPIO_IRQ_STATUS, 32'h0001);
        pins16 = 16'h0000;
        cycles(4);
        pins16 = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        bus16.bSel = 1'b1; bus16.bWrite = 1'b1;
        bus16.bAddr = GPIO_IRQ_STATUS; bus16.bWData = 32'h0001;
        @(negedge clk);
        bus_idle();
        rd(0, "collide_set_wins", GPIO_IRQ_STATUS, 32'h0001);
        cycles(2);
        wr(0, GPIO_IRQ_STATUS, 32'h0001);
        rd(0, "later_w1c", GPIO_IRQ_STATUS, 32'h0);
        chk("irq_cleared", 32'(irq16), 32'h0);

        // WIDTH=8 instance
        wr(1, GPIO_DATA_OUT, 32'hFFFF_FFFF);
        rd(1, "w8_out", GPIO_DATA_OUT, 32'h0000_00FF);
        chk("w8_pins", 32'(out8), 32'hFF);
        wr(1, 32'h24, 32'h55);
        rd(1, "w8_0x24", 32'h24, 32'h0);
        rd(1, "w8_out_kept", GPIO_DATA_OUT, 32'h0000_00FF);
        rd(1, "w8_dir_kept", GPIO_DIR, 32'h0);

        // Reset mid-traffic with pending status and pin held high
        pins16 = 16'h0000;
        cycles(3);
        wr(0, GPIO_DATA_OUT, 32'hFFFF);
        wr(0, GPIO_FALL_EN, 32'h0004);
        pins16 = 16'h0001;
        cycles(3);
        chk("pre_rst_irq", 32'(irq16), 32'h1);
        @(negedge clk);
        bus16.bSel = 1'b1; bus16.bWrite = 1'b1;
        bus16.bAddr = GPIO_DIR; bus16.bWData = 32'hAAAA;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out", 32'(out16), 32'h0);
        chk("mid_rst_oe", 32'(oe16), 32'h0);
        chk("mid_rst_irq", 32'(irq16), 32'h0);
        #1 bus_idle();
        @(negedge clk);
        rst = 1'b0;
        cycles(5);
        rd(0, "post_out", GPIO_DATA_OUT, 32'h0);
        rd(0, "post_dir", GPIO_DIR, 32'h0);
        rd(0, "post_rise", GPIO_RISE_EN, 32'h0);
        rd(0, "post_fall", GPIO_FALL_EN, 32'h0);
        rd(0, "post_status", GPIO_IRQ_STATUS, 32'h0);
        rd(0, "post_din", GPIO_DATA_IN, 32'h0001);
        chk("post_irq", 32'(irq16), 32'h0);
        rd(1, "post_w8_out", GPIO_DATA_OUT, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        errs++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $fatal(1, "timeout");
    end

endmodule
